// File: rtl/sram_pkg.sv
// Shared types and sizes for the MEM-stage external SRAM controller.
// Bus widths match the board's 256K x 16 asynchronous SRAM.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// MEM-stage controller: one 32-bit word access becomes two 16-bit SRAM
// half-accesses of WAIT cycles each, with ready low until the word is done.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned WAIT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [3:0] LAST = 4'(WAIT - 1);

    sram_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] off;
    logic        last;
    logic        hi;
    logic        rd_st;
    logic        wr_st;
    logic        unused_off;

    assign last  = (cnt_q == LAST);
    assign rd_st = (state_q == RD_LO) || (state_q == RD_HI);
    assign wr_st = (state_q == WR_LO) || (state_q == WR_HI);
    assign hi    = (state_q == RD_HI) || (state_q == WR_HI);

    // Offset bits outside the 256K x 16 window are deliberately dropped.
    assign off        = addr_q - BASE_ADDR;
    assign unused_off = ^{off[31:19], off[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WR_LO;
                    addr_d  = address;
                    wdata_d = wr_data;
                end else if (rd_en) begin
                    state_d = RD_LO;
                    addr_d  = address;
                end
            end
            RD_LO: if (last) begin
                state_d       = RD_HI;
                rdata_d[15:0] = SRAM_DQ;
            end
            RD_HI: if (last) begin
                state_d        = DONE;
                rdata_d[31:16] = SRAM_DQ;
            end
            WR_LO: if (last) state_d = WR_HI;
            WR_HI: if (last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rd_data = rdata_q;
    assign ready   = (state_q == IDLE && !rd_en && !wr_en)
                   || (state_q == DONE);

    assign SRAM_ADDR = (rd_st || wr_st) ? {off[18:2], hi} : '0;
    // WE rises one cycle before the half ends so address/data hold past it.
    assign SRAM_WE_N = !(wr_st && !last);
    assign SRAM_OE_N = !rd_st;
    assign SRAM_DQ   = wr_st ? (hi ? wdata_q[31:16] : wdata_q[15:0])
                             : {SRAM_DW{1'bz}};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT=2 and WAIT=4), each on its own
// behavioural SRAM, driven by vector tables, corner sequences and random ops.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, wd_a, rdd_a, addr_b, wd_b, rdd_b;
    logic        rdy_a, rdy_b;
    wire  [15:0] dq_a, dq_b;
    logic [17:0] sa_a, sa_b;
    logic        we_a, oe_a, ce_a, ub_a, lb_a;
    logic        we_b, oe_b, ce_b, ub_b, lb_b;

    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    sram_ctrl #(.BASE_ADDR(1024), .WAIT(2)) u_a (
        .clk(clk), .rst(rst), .rd_en(rd_a), .wr_en(wr_a),
        .address(addr_a), .wr_data(wd_a), .rd_data(rdd_a), .ready(rdy_a),
        .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a), .SRAM_WE_N(we_a),
        .SRAM_OE_N(oe_a), .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a),
        .SRAM_LB_N(lb_a)
    );

    sram_ctrl #(.BASE_ADDR(1024), .WAIT(4)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_b), .wr_en(wr_b),
        .address(addr_b), .wr_data(wd_b), .rd_data(rdd_b), .ready(rdy_b),
        .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b), .SRAM_WE_N(we_b),
        .SRAM_OE_N(oe_b), .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b),
        .SRAM_LB_N(lb_b)
    );

    // Behavioural SRAMs: combinational read, write while WE_N is low.
    assign dq_a = (!oe_a && we_a) ? mem_a[sa_a] : 16'hzzzz;
    assign dq_b = (!oe_b && we_b) ? mem_b[sa_b] : 16'hzzzz;
    always @(posedge clk) if (!we_a) mem_a[sa_a] <= dq_a;
    always @(posedge clk) if (!we_b) mem_b[sa_b] <= dq_b;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_req();
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    endtask

    // One word access; counts ready-low cycles and records WE_N lows.
    task automatic op(input bit b, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lows, output logic [7:0] wepat,
                      output logic [31:0] rdv, output int t0,
                      output int t1);
        @(negedge clk);
        if (b) begin rd_b = rd; wr_b = wr; addr_b = a; wd_b = d; end
        else   begin rd_a = rd; wr_a = wr; addr_a = a; wd_a = d; end
        lows  = 0;
        wepat = '0;
        #1;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            if (b ? rdy_b : rdy_a) break;
            if (!(b ? we_b : we_a) && i < 8) wepat[i] = 1'b1;
            lows++;
            @(posedge clk);
            #1 clr_req();
            @(negedge clk);
        end
        t1  = cyc;
        rdv = b ? rdd_b : rdd_a;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [17:0] lo;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
        logic [7:0]  exp_we;
    } vec_t;

    vec_t        tbl [4];
    logic [31:0] ref_w [16];
    logic [31:0] exp_rd;
    int          lows, t0, t1, t2, t3;
    logic [7:0]  wp;
    logic [31:0] rv;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0,
                   18'd2, 16'hBEEF, 16'hDEAD, 8'h0A};
        tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF,
                   18'd2, 16'hBEEF, 16'hDEAD, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF,
                   18'd0, 16'h5678, 16'h1234, 8'h0A};
        tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678,
                   18'd0, 16'h5678, 16'h1234, 8'h00};

        rst = 1'b0;
        clr_req();
        rd_a = 1'b1; addr_a = 32'd1028; wd_a = '0;
        addr_b = '0; wd_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready_req", {31'd0, rdy_a}, 32'd0);
        chk("rst_we_n", {31'd0, we_a}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_a}, 32'd1);
        chk("rst_rd_data", rdd_a, 32'd0);
        chk("rst_addr", {14'd0, sa_a}, 32'd0);
        rd_a = 1'b0;
        #1;
        chk("rst_ready_idle", {31'd0, rdy_a}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            op(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
               lows, wp, rv, t0, t1);
            chk($sformatf("v%0d_lows", i), lows, 5);
            chk($sformatf("v%0d_we", i), {24'd0, wp}, {24'd0, tbl[i].exp_we});
            chk($sformatf("v%0d_rd", i), rv, tbl[i].exp_rd);
            chk($sformatf("v%0d_lo", i), {16'd0, mem_a[tbl[i].lo]},
                {16'd0, tbl[i].exp_lo});
            chk($sformatf("v%0d_hi", i), {16'd0, mem_a[tbl[i].lo + 18'd1]},
                {16'd0, tbl[i].exp_hi});
        end
        repeat (3) @(negedge clk);
        chk("rd_hold", rdd_a, 32'h12345678);

        op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hA1B2C3D4, lows, wp, rv, t0, t1);
        op(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, lows, wp, rv, t2, t3);
        chk("b2b_cycles", t3 - t0 + 1, 12);
        chk("b2b_data", rv, 32'hA1B2C3D4);

        op(1'b0, 1'b0, 1'b1, 32'd1040, 32'h11112222, lows, wp, rv, t0, t1);
        @(negedge clk);
        wr_a = 1'b1; addr_a = 32'd1040; wd_a = 32'hCAFEF00D;
        @(posedge clk);
        #1 wr_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we_n", {31'd0, we_a}, 32'd1);
        chk("abort_oe_n", {31'd0, oe_a}, 32'd1);
        chk("abort_ready", {31'd0, rdy_a}, 32'd1);
        rst = 1'b1;
        chk("abort_lo", {16'd0, mem_a[8]}, 32'h0000F00D);
        chk("abort_hi", {16'd0, mem_a[9]}, 32'h00001111);
        op(1'b0, 1'b1, 1'b0, 32'd1040, 32'h0, lows, wp, rv, t0, t1);
        chk("abort_rec_lows", lows, 5);
        chk("abort_rec_data", rv, 32'h1111F00D);

        op(1'b1, 1'b0, 1'b1, 32'd1028, 32'hA5A55A5A, lows, wp, rv, t0, t1);
        chk("w4_wr_lows", lows, 9);
        chk("w4_we", {24'd0, wp}, 32'h000000EE);
        chk("w4_lo", {16'd0, mem_b[2]}, 32'h00005A5A);
        chk("w4_hi", {16'd0, mem_b[3]}, 32'h0000A5A5);
        op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, lows, wp, rv, t0, t1);
        chk("w4_rd_lows", lows, 9);
        chk("w4_rd_data", rv, 32'hA5A55A5A);

        exp_rd = 32'h1111F00D;
        for (int i = 0; i < 16; i++) begin
            ref_w[i] = $urandom;
            op(1'b0, 1'b0, 1'b1, 32'd1024 + 32'(i * 4), ref_w[i],
               lows, wp, rv, t0, t1);
            chk($sformatf("fill%0d_lows", i), lows, 5);
        end
        for (int n = 0; n < 40; n++) begin
            int unsigned idx, kind;
            logic [31:0] a, d;
            idx  = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            d    = $urandom;
            a    = 32'd1024 + (idx << 2) + ($urandom_range(0, 8191) << 19)
                 + $urandom_range(0, 3);
            op(1'b0, kind != 1, kind != 0, a, d, lows, wp, rv, t0, t1);
            if (kind == 0) exp_rd = ref_w[idx];
            else           ref_w[idx] = d;
            chk($sformatf("rnd%0d_lows", n), lows, 5);
            chk($sformatf("rnd%0d_rd", n), rv, exp_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
